// File: rtl/shift_seq_reg.sv
// Universal shift register with a multi-cycle sequencer. A start pulse either
// acts in one edge (hold/load/clear) or runs a shift/rotate one bit per clock.
module shift_seq_reg #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amt,
  input  logic [WIDTH-1:0] d,
  input  logic             sr,
  input  logic             sl,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  state_e           state, state_nx;
  op_e              op_r, op_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic [CNT_W-1:0] amt_sat;
  logic [WIDTH-1:0] q_nx;
  logic             so_nx;
  logic             done_nx;

  // One bit-step of the captured operation; returns {shifted-out bit, new q}.
  function automatic logic [WIDTH:0] step(input op_e o, input logic [WIDTH-1:0] v,
                                           input logic s_r, input logic s_l,
                                           input logic so_cur);
    case (o)
      OP_SHR:  return {v[0],       s_r,        v[WIDTH-1:1]};
      OP_SHL:  return {v[WIDTH-1], v[WIDTH-2:0], s_l};
      OP_ROR:  return {v[0],       v[0],       v[WIDTH-1:1]};
      OP_ROL:  return {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_ASR:  return {v[0],       v[WIDTH-1], v[WIDTH-1:1]};
      default: return {so_cur, v};
    endcase
  endfunction

  assign amt_sat = (amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amt;
  assign busy    = (state == S_SHIFT);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nx = state;
    op_nx    = op_r;
    count_nx = count;
    q_nx     = q;
    so_nx    = so;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (op_e'(op))
            OP_HOLD: done_nx = 1'b1;
            OP_LOAD: begin
              q_nx    = d;
              done_nx = 1'b1;
            end
            OP_CLR: begin
              q_nx    = '0;
              done_nx = 1'b1;
            end
            default: begin
              if (amt_sat == '0) begin
                done_nx = 1'b1;
              end else begin
                state_nx = S_SHIFT;
                op_nx    = op_e'(op);
                count_nx = amt_sat;
              end
            end
          endcase
        end
      end
      S_SHIFT: begin
        // Abort freezes the partial result: no step on the aborting edge, no done.
        if (abort) begin
          state_nx = S_IDLE;
          count_nx = '0;
        end else begin
          {so_nx, q_nx} = step(op_r, q, sr, sl, so);
          count_nx      = count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_r  <= OP_HOLD;
      count <= '0;
      q     <= '0;
      so    <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      op_r  <= op_nx;
      count <= count_nx;
      q     <= q_nx;
      so    <= so_nx;
      done  <= done_nx;
    end
  end

endmodule

// File: tb/tb_shift_seq_reg.sv
// Self-checking bench for shift_seq_reg (WIDTH=8): directed scenarios with a
// cycle-level behavioural model compared on every falling edge.
module tb_shift_seq_reg;

  localparam int W     = 8;
  localparam int CNT_W = $clog2(W + 1);

  localparam logic [2:0] HOLD = 3'b000, SHR = 3'b001, SHL = 3'b010, LOAD = 3'b011,
                         ROR  = 3'b100, ROL = 3'b101, ASR = 3'b110, CLR  = 3'b111;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, sr, sl, abort;
  logic [2:0]       op;
  logic [CNT_W-1:0] amt;
  logic [W-1:0]     d;
  logic [W-1:0]     q;
  logic             so, busy, done;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int busy_seen = 0;

  shift_seq_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .amt(amt), .d(d),
    .sr(sr), .sl(sl), .abort(abort), .q(q), .so(so), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: shifts expressed as plain arithmetic on the register value.
  logic [W-1:0] m_q;
  logic         m_so, m_busy, m_done;
  logic [2:0]   m_op;
  int           m_left;

  function automatic logic [W:0] model_step(input logic [2:0] o, input logic [W-1:0] v,
                                            input logic s_r, input logic s_l);
    case (o)
      SHR:     return {v[0],   (v >> 1) | (8'(s_r) << 7)};
      SHL:     return {v[W-1], (v << 1) | 8'(s_l)};
      ROR:     return {v[0],   (v >> 1) | (v << 7)};
      ROL:     return {v[W-1], (v << 1) | (v >> 7)};
      ASR:     return {v[0],   (v >> 1) | (v & 8'h80)};
      default: return {1'b0, v};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0; m_so <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0; m_op <= HOLD;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          case (op)
            HOLD: m_done <= 1'b1;
            LOAD: begin m_q <= d;  m_done <= 1'b1; end
            CLR:  begin m_q <= '0; m_done <= 1'b1; end
            default: begin
              m_op   <= op;
              m_left <= (int'(amt) > W) ? W : int'(amt);
              if (amt == '0) m_done <= 1'b1;
              else           m_busy <= 1'b1;
            end
          endcase
        end
      end else if (abort) begin
        m_busy <= 1'b0;
      end else begin
        {m_so, m_q} <= model_step(m_op, m_q, sr, sl);
        m_left      <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc q", q, m_q);
    check("cyc so", so, m_so);
    check("cyc busy", busy, m_busy);
    check("cyc done", done, m_done);
    if (done) done_seen++;
    if (busy) busy_seen++;
  end

  // Called at posedge+1; holds start for exactly one edge.
  task automatic op_start(input logic [2:0] o, input int a, input logic [W-1:0] dv);
    start = 1'b1; op = o; amt = CNT_W'(a); d = dv;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check({name, " done seen"}, 64'(seen), 64'd1);
  endtask

  int d0, b0;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = HOLD; amt = '0; d = '0;
    sr = 1'b0; sl = 1'b0; abort = 1'b0;
    #2;
    check("reset q", q, 8'h00);
    check("reset busy/done", {busy, done}, 2'b00);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // LOAD: single edge, one done pulse, never busy.
    d0 = done_seen; b0 = busy_seen;
    op_start(LOAD, 0, 8'hA5);
    check("load q", q, 8'hA5);
    check("load done", done, 1'b1);
    @(posedge clk); #1;
    check("load done count", done_seen - d0, 1);
    check("load busy count", busy_seen - b0, 0);

    // ROL 3 on 0x81, then ROR 9 saturating to a full rotation.
    op_start(LOAD, 0, 8'h81);
    wait_done("ld81");
    @(posedge clk); #1;
    d0 = done_seen; b0 = busy_seen;
    op_start(ROL, 3, 8'h00);
    wait_done("rol3");
    check("rol3 q", q, 8'h0C);
    check("rol3 so", so, 1'b0);
    @(posedge clk); #1;
    check("rol3 busy count", busy_seen - b0, 3);
    check("rol3 done count", done_seen - d0, 1);
    op_start(ROR, 9, 8'h00);
    wait_done("ror9");
    check("ror9 q", q, 8'h0C);

    // ASR 2 on 0x80, then SHR 4 with sr=1.
    op_start(LOAD, 0, 8'h80);
    wait_done("ld80");
    op_start(ASR, 2, 8'h00);
    wait_done("asr2");
    check("asr2 q", q, 8'hE0);
    check("asr2 so", so, 1'b0);
    sr = 1'b1;
    op_start(SHR, 4, 8'h00);
    wait_done("shr4");
    check("shr4 q", q, 8'hFE);
    sr = 1'b0;

    // SHL 5 on 0xFF with abort after two steps; start while busy ignored.
    op_start(LOAD, 0, 8'hFF);
    wait_done("ldff");
    @(posedge clk); #1;
    d0 = done_seen;
    op_start(SHL, 5, 8'h00);
    start = 1'b1; op = LOAD; d = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort q", q, 8'hFC);
    check("abort so", so, 1'b1);
    check("abort busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("abort done count", done_seen - d0, 0);

    // Zero-length shift, then start and abort together in IDLE.
    op_start(SHR, 0, 8'h00);
    check("shr0 done", done, 1'b1);
    check("shr0 q", q, 8'hFC);
    abort = 1'b1;
    op_start(LOAD, 0, 8'h3C);
    abort = 1'b0;
    check("start+abort q", q, 8'h3C);
    check("start+abort done", done, 1'b1);

    // Asynchronous reset in the middle of a shift.
    @(posedge clk); #1;
    op_start(ROL, 8, 8'h00);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst q", q, 8'h00);
    check("midrst so/busy/done", {so, busy, done}, 3'b000);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post rst q", q, 8'h00);
    check("post rst busy/done", {busy, done}, 2'b00);

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
